// File: rtl/lab5_led_pkg.sv
// Shared constants and FSM encoding for the red-LED PIO write arbiter.
package lab5_led_pkg;

  localparam int         LED_W         = 16;
  localparam int         PIO_DATA_W    = 32;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/lab5_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module lab5_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lab5_led_write_arbiter.sv
// Avalon-MM write master sharing the 16-bit red-LED PIO between NUM_REQ
// requesters: round-robin grant, masked merge into a shadow, one write per grant.
module lab5_led_write_arbiter
  import lab5_led_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 0,
  parameter int LED_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] req_data,
  input  logic [NUM_REQ*LED_W-1:0] req_mask,
  output logic [NUM_REQ-1:0]       ack,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic [LED_W-1:0]         led_value,
  output logic [1:0]               pio_address,
  output logic                     pio_chipselect,
  output logic                     pio_write_n,
  output logic [31:0]              pio_writedata
);

  // Handshake: req is a level sampled only in IDLE; ack pulses for exactly the
  // cycle in which that requester's write is on the bus. A req still high when
  // the arbiter is back in IDLE counts as a fresh request.

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  gnt;
  logic              any_req;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LED_W-1:0]  shadow;
  logic [LED_W-1:0]  merged;
  logic [LED_W-1:0]  merged_next;
  logic [LED_W-1:0]  sel_data;
  logic [LED_W-1:0]  sel_mask;

  lab5_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  always_comb begin
    sel_data = '0;
    sel_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        sel_data = req_data[i*LED_W +: LED_W];
        sel_mask = req_mask[i*LED_W +: LED_W];
      end
    end
    merged_next = (shadow & ~sel_mask) | (sel_data & sel_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = WRITE;
      WRITE:   state_next = (HOLD_CYCLES > 0) ? HOLD : IDLE;
      HOLD:    if (hold_cnt == HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes, ack and busy are loaded one edge early so they line up with the
  // state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      gnt            <= '0;
      hold_cnt       <= '0;
      shadow         <= '0;
      merged         <= '0;
      ack            <= '0;
      grant_id       <= '0;
      busy           <= 1'b0;
      pio_address    <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      ack            <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= PIO_ADDR_DATA;
      busy           <= (state_next != IDLE);
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt            <= pick;
            grant_id       <= 3'(pick);
            merged         <= merged_next;
            ack            <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_writedata  <= {{(PIO_DATA_W-LED_W){1'b0}}, merged_next};
          end
        end
        WRITE: begin
          shadow   <= merged;
          hold_cnt <= '0;
          rr_ptr   <= (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
        HOLD: begin
          hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign led_value = shadow;

endmodule

// File: tb/tb_lab5_led_write_arbiter.sv
// Scoreboard bench: drivers push expected PIO writes, monitors pop and compare.
module tb_lab5_led_write_arbiter;

  localparam int EXP_W = 35;  // {grant id[2:0], writedata[31:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with no hold interval.
  logic        rst0 = 1'b1;
  logic [2:0]  req0 = '0;
  logic [47:0] data0 = '0;
  logic [47:0] mask0 = '0;
  logic [2:0]  ack0;
  logic [2:0]  gid0;
  logic        busy0;
  logic [15:0] led0;
  logic [1:0]  addr0;
  logic        cs0;
  logic        wn0;
  logic [31:0] wd0;

  // Instance with a 4-cycle hold interval.
  logic        rst_h = 1'b1;
  logic [2:0]  req_h = '0;
  logic [47:0] data_h = '0;
  logic [47:0] mask_h = '0;
  logic [2:0]  ack_h;
  logic [2:0]  gid_h;
  logic        busy_h;
  logic [15:0] led_h;
  logic [1:0]  addr_h;
  logic        cs_h;
  logic        wn_h;
  logic [31:0] wd_h;

  lab5_led_write_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(0), .LED_W(16)) dut (
    .clk(clk), .reset(rst0), .req(req0), .req_data(data0), .req_mask(mask0),
    .ack(ack0), .grant_id(gid0), .busy(busy0), .led_value(led0),
    .pio_address(addr0), .pio_chipselect(cs0), .pio_write_n(wn0),
    .pio_writedata(wd0)
  );

  lab5_led_write_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4), .LED_W(16)) dut_h (
    .clk(clk), .reset(rst_h), .req(req_h), .req_data(data_h), .req_mask(mask_h),
    .ack(ack_h), .grant_id(gid_h), .busy(busy_h), .led_value(led_h),
    .pio_address(addr_h), .pio_chipselect(cs_h), .pio_write_n(wn_h),
    .pio_writedata(wd_h)
  );

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_h_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int gap0   = 0;       // required strobe spacing on dut, 0 = unchecked
  bit hold_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor, no-hold instance ----------------
  initial begin : mon0
    logic [EXP_W-1:0] e;
    int cyc = 0;
    int prev = 0;
    bit prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (gap0 == 0) prev_valid = 1'b0;
      check("strobe_pair", {31'b0, cs0}, {31'b0, ~wn0});
      if (cs0 && !wn0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", wd0, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("writedata", wd0, e[31:0]);
          check("grant_id", {29'b0, gid0}, {29'b0, e[34:32]});
          check("ack", {29'b0, ack0}, 32'(3'b001 << e[34:32]));
          check("address", {30'b0, addr0}, 32'h0);
        end
        if (prev_valid) check("write_gap", cyc - prev, gap0);
        prev = cyc;
        prev_valid = 1'b1;
      end else if (ack0 != 3'b000) begin
        check("stray_ack", {29'b0, ack0}, 32'h0);
      end
    end
  end

  // ---------------- scoreboard monitor, hold instance ----------------
  initial begin : mon_h
    logic [EXP_W-1:0] e;
    int cyc = 0;
    int prev = 0;
    bit prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!hold_phase) prev_valid = 1'b0;
      if (cs_h && !wn_h) begin
        if (exp_h_q.size() == 0) begin
          check("h_unexpected_write", wd_h, 32'hFFFF_FFFF);
        end else begin
          e = exp_h_q.pop_front();
          check("h_writedata", wd_h, e[31:0]);
          check("h_ack", {29'b0, ack_h}, 32'(3'b001 << e[34:32]));
          check("h_busy_write", {31'b0, busy_h}, 32'h1);
        end
        if (prev_valid) check("h_write_gap", cyc - prev, 6);
        prev = cyc;
        prev_valid = 1'b1;
      end else if (prev_valid && (cyc - prev) <= 5) begin
        // Four HOLD cycles (busy) then one IDLE cycle (not busy).
        check("h_busy", {31'b0, busy_h}, {31'b0, (cyc - prev) <= 4});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req0(input int idx, input logic [15:0] d, input logic [15:0] m);
    data0[idx*16 +: 16] = d;
    mask0[idx*16 +: 16] = m;
    req0[idx] = 1'b1;
  endtask

  task automatic push0(input logic [2:0] id, input logic [15:0] d);
    exp_q.push_back({id, 16'h0000, d});
  endtask

  // Returns at the negedge of the n-th ack cycle (inside the WRITE cycle).
  task automatic wait_acks0(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 200) begin
      @(negedge clk);
      if (ack0 != 3'b000) seen++;
      budget++;
    end
    if (seen < n) check("ack_timeout", seen, n);
  endtask

  task automatic wait_acks_h(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 200) begin
      @(negedge clk);
      if (ack_h != 3'b000) seen++;
      budget++;
    end
    if (seen < n) check("h_ack_timeout", seen, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    repeat (3) @(negedge clk);
    rst0  = 1'b0;
    rst_h = 1'b0;

    // Idle after reset: no strobes, LEDs dark, not busy.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_cs", {31'b0, cs0}, 32'h0);
      check("idle_wn", {31'b0, wn0}, 32'h1);
      check("idle_led", {16'b0, led0}, 32'h0);
      check("idle_busy", {31'b0, busy0}, 32'h0);
    end
    check("idle_wd", wd0, 32'h0);
    check("h_idle_busy", {31'b0, busy_h}, 32'h0);

    // Full-mask write from requester 0.
    push0(3'd0, 16'hA5A5);
    set_req0(0, 16'hA5A5, 16'hFFFF);
    wait_acks0(1);
    req0 = '0;
    data0[15:0] = 16'h1111;   // changes after the grant must not matter
    @(negedge clk);
    check("led_after_r0", {16'b0, led0}, 32'h0000_A5A5);

    // Masked merge: (A5A5 & ~0F0F) | (00FF & 0F0F) = A0AF.
    push0(3'd1, 16'hA0AF);
    set_req0(1, 16'h00FF, 16'h0F0F);
    wait_acks0(1);
    req0 = '0;
    @(negedge clk);
    check("led_after_merge", {16'b0, led0}, 32'h0000_A0AF);

    // All-zero mask: write still issues with the unchanged shadow.
    push0(3'd2, 16'hA0AF);
    set_req0(2, 16'hFFFF, 16'h0000);
    wait_acks0(1);
    req0 = '0;
    @(negedge clk);
    check("led_after_zero_mask", {16'b0, led0}, 32'h0000_A0AF);

    // All three held: rotate 0,1,2,0,1,2 with a write every 2 cycles.
    for (int r = 0; r < 2; r++) begin
      push0(3'd0, 16'h1111);
      push0(3'd1, 16'h2222);
      push0(3'd2, 16'h3333);
    end
    gap0 = 2;
    set_req0(0, 16'h1111, 16'hFFFF);
    set_req0(1, 16'h2222, 16'hFFFF);
    set_req0(2, 16'h3333, 16'hFFFF);
    wait_acks0(6);
    req0 = '0;
    gap0 = 0;
    @(negedge clk);
    check("led_after_rotate", {16'b0, led0}, 32'h0000_3333);

    // Reset lands on the WRITE cycle: strobes drop, no ack, shadow cleared.
    push0(3'd1, 16'hBEEF);
    set_req0(1, 16'hBEEF, 16'hFFFF);
    wait_acks0(1);
    req0 = '0;
    rst0 = 1'b1;
    @(negedge clk);
    check("rst_cs", {31'b0, cs0}, 32'h0);
    check("rst_wn", {31'b0, wn0}, 32'h1);
    check("rst_ack", {29'b0, ack0}, 32'h0);
    check("rst_led", {16'b0, led0}, 32'h0);
    check("rst_busy", {31'b0, busy0}, 32'h0);
    rst0 = 1'b0;

    // After reset the pointer is back at 0: requester 0 wins, merge from zero.
    push0(3'd0, 16'h0034);
    push0(3'd1, 16'h5678);
    set_req0(0, 16'h1234, 16'h00FF);
    set_req0(1, 16'h5678, 16'hFFFF);
    wait_acks0(2);
    req0 = '0;
    @(negedge clk);
    check("led_after_rst", {16'b0, led0}, 32'h0000_5678);

    // Hold interval of 4: requester 2 held, writes exactly 6 cycles apart.
    for (int i = 0; i < 4; i++) exp_h_q.push_back({3'd2, 32'h0000_00C3});
    hold_phase = 1'b1;
    data_h[47:32] = 16'h55C3;
    mask_h[47:32] = 16'h00FF;
    req_h[2] = 1'b1;
    wait_acks_h(4);
    req_h = '0;
    repeat (8) @(negedge clk);
    hold_phase = 1'b0;
    check("h_led", {16'b0, led_h}, 32'h0000_00C3);
    check("h_idle_end", {31'b0, busy_h}, 32'h0);

    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp_h_q.size() != 0); i++)
      @(negedge clk);
    check("leftover_exp", exp_q.size(), 0);
    check("leftover_exp_h", exp_h_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lab5_led_write_arbiter.md
Name: lab5_led_write_arbiter

Overview:
- Avalon-MM write master that shares the 16-bit red-LED PIO slave (s1: address, chipselect, write_n, writedata) between NUM_REQ hardware requesters.
- Each requester asks for a masked update of the LED value.
- Block arbitrates round-robin, merges the update into a shadow copy of the LED register, and issues one single-cycle PIO write per grant.
- An optional hold interval keeps each pattern visible before the next grant.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 0, idle cycles after each write before re-arbitration (0 = none).
- LED_W, 16, LED register width; fixed to the PIO width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester update request, level.
- req_data  input  NUM_REQ*LED_W  flattened new LED values; slice i belongs to requester i.
- req_mask  input  NUM_REQ*LED_W  flattened bit enables; 1 = take the bit from req_data.
- ack  output  NUM_REQ  one-cycle pulse to the granted requester when its write issues.
- grant_id  output  3  index of the last granted requester.
- busy  output  1  high in any state other than IDLE.
- led_value  output  LED_W  shadow of the value last written to the PIO.
- pio_address  output  2  to PIO s1; always 0.
- pio_chipselect  output  1  to PIO s1.
- pio_write_n  output  1  to PIO s1, active-low.
- pio_writedata  output  32  to PIO s1.

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (sampled at posedge clk) sets:
  - state = IDLE, rr_ptr = 0, shadow = 0, hold_cnt = 0.
  - pio_chipselect = 0, pio_write_n = 1, pio_address = 0, pio_writedata = 0.
  - ack = 0, grant_id = 0, busy = 0.
- All outputs are registered.
- FSM states: IDLE, WRITE, HOLD.
- IDLE, cycle T, with any req bit set:
  - Select the first asserted req at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch g into grant_id.
  - Register merged = (shadow & ~req_mask[g]) | (req_data[g] & req_mask[g]).
  - Go to WRITE. No req means stay in IDLE.
- WRITE, cycle T+1 (exactly one cycle):
  - pio_chipselect = 1, pio_write_n = 0, pio_address = 0, pio_writedata = {16'b0, merged}.
  - ack[g] = 1. shadow and led_value take merged at the end of this cycle.
  - rr_ptr = (g+1) mod NUM_REQ.
  - Next state is HOLD if HOLD_CYCLES > 0, otherwise IDLE.
- The PIO has no wait states, so no waitrequest handling is needed.
- HOLD: strobes inactive. hold_cnt counts up to HOLD_CYCLES-1, then IDLE. hold_cnt width is clog2(HOLD_CYCLES+1).
- Throughput: back-to-back requests are granted every 2+HOLD_CYCLES cycles.
- Request rules:
  - req is sampled only in IDLE. Data and mask are captured at the grant edge; later changes are ignored.
  - Deasserting req after the grant edge does not cancel the write.
  - A req still high in IDLE after ack counts as a new request.
- All-zero mask: the write still issues with merged = shadow, and ack pulses.
- Simultaneous requests: only one grant per arbitration. Losers wait with no starvation (bounded by NUM_REQ grants).
- Reset in WRITE or HOLD: strobes drop at that edge, no ack, shadow = 0. The PIO resets separately, so the shadow mirrors PIO state only when both are reset together (system reset).
- pio_writedata[31:16] is always 0.

Decomposition:
- Package lab5_led_pkg:
  - LED_W = 16, PIO_DATA_W = 32, PIO_ADDR_DATA = 2'd0.
  - State enum {IDLE, WRITE, HOLD}.
- Sub-module lab5_rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any_req.
  - Reused elsewhere for other PIO sharers.

Test Plan:
- Reset then idle → pio_write_n=1, pio_chipselect=0, led_value=0x0000, busy=0 for 20 cycles.
- req[0]=1, data=0xA5A5, mask=0xFFFF, held until ack → one WRITE cycle with pio_writedata=0x0000A5A5 and ack[0] at T+1; led_value=0xA5A5 afterwards.
- Masked merge: shadow=0xA5A5, req[1] with data=0x00FF, mask=0x0F0F → writedata=0x0000A0AF, led_value=0xA0AF.
- All three req held continuously, HOLD_CYCLES=0 → grants 0,1,2,0,… with write strobes every 2 cycles and no requester skipped.
- HOLD_CYCLES=4, req[2] held → writes exactly 6 cycles apart; busy low only in IDLE cycles.
- Reset asserted during WRITE → strobes inactive the next cycle, no ack, led_value=0; a req after reset release is granted from req[0] priority.
